stream_upsizer: RTL and testbench
=================================

// Module: stream_upsizer
// PURPOSE
//  Packs RATIO consecutive narrow ready/valid beats into one wide beat. A stream-level last
//  flag may close a wide beat early. Sits directly downstream of the fall-through register on
//  the narrow ingress stream and feeds the wide AXI-side datapath. Output is fully registered
//  (data/valid/keep/last); ready_o depends combinationally on ready_i only while a beat is held.
// PARAMETERS
//  IN_W   32  narrow data width in bits (>=1)
//  RATIO  4   narrow beats per wide beat; RATIO<2 -> $error at elaboration
//  CNT_W  16  width of wide-beat counter (optional feature only)
// PORTS
//  clk_i       in   1            clock, all state on rising edge
//  rst_i       in   1            asynchronous active-high reset
//  clr_i       in   1            synchronous clear, same effect as reset
//  valid_i     in   1            narrow beat valid
//  ready_o     out  1            narrow beat accepted when valid_i & ready_o
//  data_i      in   IN_W         narrow data
//  last_i      in   1            narrow beat is last of packet; closes current wide beat
//  valid_o     out  1            wide beat valid
//  ready_i     in   1            wide beat consumed when valid_o & ready_i
//  data_o      out  IN_W*RATIO   wide data; lane k = data_o[k*IN_W +: IN_W], lane 0 = first beat
//  keep_o      out  RATIO        lane-k-filled flags, always contiguous from bit 0
//  last_o      out  1            wide beat closes a packet
//  wbeat_cnt_o out  CNT_W        wide beats emitted (present only with the macro)
// BEHAVIOUR
//  - Reset/clr_i: state=FILL, idx=0, valid_o=0, data_o=0, keep_o=0, last_o=0, wbeat_cnt_o=0.
//    clr_i overrides any same-cycle handshake; asserting reset mid-packet discards partial data.
//  - idx: lane write pointer, $clog2(RATIO) bits, range 0..RATIO-1; never wraps past RATIO-1.
//  - FILL: valid_o=0, ready_o=1. On input handshake: lane idx<=data_i, keep_o[idx]<=1.
//      idx==RATIO-1 or last_i -> HOLD, valid_o<=1, last_o<=last_i, idx<=0; else idx<=idx+1.
//  - HOLD: valid_o=1, outputs stable until handshake; ready_o=ready_i.
//      pop without push -> FILL, valid_o<=0, data_o<=0, keep_o<=0, last_o<=0.
//      pop with push (same cycle) -> new beat lands in lane 0, other lanes zeroed, keep_o<=1,
//        idx<=1, stay FILL; if last_i on that beat -> stay HOLD with keep_o=1, last_o=1.
//  - Unfilled lanes of an early-closed beat are driven 0.
//  - Latency: wide beat valid 1 cycle after the completing narrow handshake.
//  - Throughput: with ready_i held high, no bubbles: one narrow beat every cycle.
//  - valid_i/data_i/last_i are not required to be stable while ready_o=0 (AXI-stream rules
//    expected upstream; no internal check).
// CONFIGURATION
//  STREAM_UPSIZER_WBEAT_CNT_EN defined: wbeat_cnt_o port exists; increments on every
//    valid_o&ready_i, wraps 2^CNT_W-1 -> 0, cleared by reset/clr_i.
//  Not defined: port and counter absent; datapath behaviour identical.
// TESTING
//  1. RATIO=4, IN_W=8, ready_i=1, beats 0x11,0x22,0x33,0x44 back to back -> next cycle
//     valid_o=1, data_o=0x44332211, keep_o=4'b1111, last_o=0.
//  2. Beats 0xAA, 0xBB(last_i=1) -> data_o=0x0000BBAA, keep_o=4'b0011, last_o=1, idx back to 0.
//  3. Wide beat held with ready_i=0 for 5 cycles -> ready_o=0, outputs stable; then ready_i=1
//     with valid_i=1, data_i=0x55 -> pop and push same cycle, next data_o lane0=0x55, keep_o=0001.
//  4. Single beat 0x77 with last_i=1 while a beat is popped -> stays HOLD, keep_o=0001, last_o=1.
//  5. Assert clr_i after 2 of 4 beats, then send 4 beats 0x01..0x04 -> data_o=0x04030201 only.
//  6. Macro defined, CNT_W=2: emit 5 wide beats -> wbeat_cnt_o 1,2,3,0,1; async rst_i mid-beat
//     -> valid_o, keep_o, cnt drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stream_upsizer.sv
// stream_upsizer
//   Packs RATIO consecutive narrow ready/valid beats into one wide beat, lane 0
//   holding the first narrow beat. A narrow beat with last_i set closes the wide
//   beat early; lanes that were never filled are driven to zero and keep_o marks
//   the filled lanes, always contiguous from bit 0.
//   The wide output (data/valid/keep/last) is fully registered. ready_o is
//   constant 1 while a wide beat is being filled, and follows ready_i while a
//   complete wide beat is being held.
//
// Optional feature (compile-time macro STREAM_UPSIZER_WBEAT_CNT_EN):
//   Adds the wbeat_cnt_o port, a CNT_W-bit count of wide beats consumed
//   (valid_o & ready_i). It wraps to 0 and is cleared by rst_i or clr_i.
//   Without the macro, the port and the counter are absent and the datapath
//   behaves identically.
//
// Ports
//   clk_i        in   clock, all state on the rising edge
//   rst_i        in   asynchronous active-high reset
//   clr_i        in   synchronous clear, same effect as reset
//   valid_i      in   narrow beat valid
//   ready_o      out  narrow beat accepted when valid_i & ready_o
//   data_i       in   narrow data [IN_W]
//   last_i       in   narrow beat ends the packet and closes the wide beat
//   valid_o      out  wide beat valid
//   ready_i      in   wide beat consumed when valid_o & ready_i
//   data_o       out  wide data [IN_W*RATIO]; lane k = data_o[k*IN_W +: IN_W]
//   keep_o       out  per-lane filled flags [RATIO]
//   last_o       out  wide beat closes a packet
//   wbeat_cnt_o  out  count of wide beats emitted [CNT_W] (macro only)
module stream_upsizer #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned RATIO = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [IN_W-1:0]       data_i,
  input  logic                  last_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [IN_W*RATIO-1:0] data_o,
  output logic [RATIO-1:0]      keep_o,
  output logic                  last_o
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
  ,
  output logic [CNT_W-1:0]      wbeat_cnt_o
`endif
);

  if (RATIO < 2) begin : g_bad_ratio
    $error("stream_upsizer: RATIO must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("stream_upsizer: CNT_W must be at least 1");
  end

  localparam int unsigned     IDX_W    = (RATIO < 2) ? 1 : $clog2(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [RATIO-1:0] KEEP_L0  = {{(RATIO-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t                 r_state,  w_state_nxt;
  logic [IDX_W-1:0]       r_idx,    w_idx_nxt;
  logic [IN_W*RATIO-1:0]  r_data,   w_data_nxt;
  logic [RATIO-1:0]       r_keep,   w_keep_nxt;
  logic                   r_valid,  w_valid_nxt;
  logic                   r_last,   w_last_nxt;
  logic                   w_push;
  logic                   w_pop;

  assign ready_o = (r_state == S_FILL) | ready_i;
  assign w_push  = valid_i & ready_o;
  assign w_pop   = r_valid & ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_keep_nxt  = r_keep;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    case (r_state)
      S_FILL: begin
        if (w_push) begin
          w_data_nxt[r_idx*IN_W +: IN_W] = data_i;
          w_keep_nxt[r_idx]              = 1'b1;
          if ((r_idx == IDX_LAST) || last_i) begin
            w_state_nxt = S_HOLD;
            w_valid_nxt = 1'b1;
            w_last_nxt  = last_i;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_pop) begin
          // Emptying the wide register on pop is what keeps unfilled lanes of
          // a later early-closed beat at zero.
          w_state_nxt = S_FILL;
          w_valid_nxt = 1'b0;
          w_data_nxt  = '0;
          w_keep_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_idx_nxt   = '0;
          if (w_push) begin
            // Same-cycle refill: the incoming beat starts the next wide beat.
            w_data_nxt[IN_W-1:0] = data_i;
            w_keep_nxt           = KEEP_L0;
            w_idx_nxt            = IDX_W'(1);
            if (last_i) begin
              w_state_nxt = S_HOLD;
              w_valid_nxt = 1'b1;
              w_last_nxt  = 1'b1;
              w_idx_nxt   = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (clr_i) begin
      r_state <= S_FILL;
      r_idx   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_keep  <= w_keep_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign keep_o  = r_keep;
  assign last_o  = r_last;

`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
  logic [CNT_W-1:0] r_wbeat_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wbeat_cnt <= '0;
    end else if (clr_i) begin
      r_wbeat_cnt <= '0;
    end else if (w_pop) begin
      r_wbeat_cnt <= r_wbeat_cnt + 1'b1;
    end
  end

  assign wbeat_cnt_o = r_wbeat_cnt;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
module tb_stream_upsizer;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned CNT_W = 2;

  logic                  clk_i   = 1'b0;
  logic                  rst_i   = 1'b1;
  logic                  clr_i   = 1'b0;
  logic                  valid_i = 1'b0;
  logic                  ready_o;
  logic [IN_W-1:0]       data_i  = '0;
  logic                  last_i  = 1'b0;
  logic                  valid_o;
  logic                  ready_i = 1'b1;
  logic [IN_W*RATIO-1:0] data_o;
  logic [RATIO-1:0]      keep_o;
  logic                  last_o;
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
  logic [CNT_W-1:0]      wbeat_cnt_o;
`endif

  stream_upsizer #(
    .IN_W (IN_W),
    .RATIO(RATIO),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .last_i (last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .keep_o (keep_o),
    .last_o (last_o)
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
    ,
    .wbeat_cnt_o(wbeat_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard entry: {data, keep, last}
  typedef struct packed {
    logic [IN_W*RATIO-1:0] data;
    logic [RATIO-1:0]      keep;
    logic                  last;
  } wbeat_t;

  wbeat_t q[$];

  // Packing model of the narrow stream
  logic [IN_W*RATIO-1:0] acc_data = '0;
  logic [RATIO-1:0]      acc_keep = '0;
  int unsigned           acc_n    = 0;
  logic [CNT_W-1:0]      cnt_model = '0;

  task automatic model_clear();
    acc_data  = '0;
    acc_keep  = '0;
    acc_n     = 0;
    cnt_model = '0;
  endtask

  task automatic model_accept(input logic [IN_W-1:0] d, input logic l);
    wbeat_t b;
    acc_data[acc_n*IN_W +: IN_W] = d;
    acc_keep[acc_n] = 1'b1;
    acc_n++;
    if (acc_n == RATIO || l) begin
      b.data = acc_data;
      b.keep = acc_keep;
      b.last = l;
      q.push_back(b);
      acc_data = '0;
      acc_keep = '0;
      acc_n    = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
    int unsigned waited = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", 64'(waited), 64'd0);
        valid_i = 1'b0;
        last_i  = 1'b0;
        return;
      end
    end
    @(posedge clk_i);
    #1;
    model_accept(d, l);
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Output monitor: a handshake is decided at the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i && !clr_i && valid_o && ready_i) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_beat", 64'(data_o), 64'd0);
      end else begin
        chk("sb_data", 64'(data_o), 64'(q[0].data));
        chk("sb_keep", 64'(keep_o), 64'(q[0].keep));
        chk("sb_last", 64'(last_o), 64'(q[0].last));
        void'(q.pop_front());
      end
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
      chk("cnt_before_pop", 64'(wbeat_cnt_o), 64'(cnt_model));
      cnt_model = cnt_model + 1'b1;
`endif
    end
  end

  initial begin
    #12;
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_keep",  64'(keep_o),  64'd0);
    chk("rst_data",  64'(data_o),  64'd0);
    chk("rst_last",  64'(last_o),  64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
    chk("rst_cnt",   64'(wbeat_cnt_o), 64'd0);
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_clear();
    tick(1);

    // 1: four back-to-back beats
    ready_i = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_data",  64'(data_o),  64'h44332211);
    chk("t1_keep",  64'(keep_o),  64'hF);
    chk("t1_last",  64'(last_o),  64'd0);
    tick(2);

    // 2: early close by last_i
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    chk("t2_data", 64'(data_o), 64'h0000BBAA);
    chk("t2_keep", 64'(keep_o), 64'h3);
    chk("t2_last", 64'(last_o), 64'd1);
    tick(2);
    // lane pointer restarts at 0
    send_beat(8'hC1, 1'b0);
    send_beat(8'hC2, 1'b0);
    send_beat(8'hC3, 1'b0);
    send_beat(8'hC4, 1'b0);
    chk("t2_restart_data", 64'(data_o), 64'hC4C3C2C1);
    tick(2);

    // 3: back-pressure hold, then pop and push in the same cycle
    ready_i = 1'b0;
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b0);
    send_beat(8'hA3, 1'b0);
    send_beat(8'hA4, 1'b0);
    valid_i = 1'b1;
    data_i  = 8'h99;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t3_hold_ready", 64'(ready_o), 64'd0);
      chk("t3_hold_valid", 64'(valid_o), 64'd1);
      chk("t3_hold_data",  64'(data_o),  64'hA4A3A2A1);
      @(posedge clk_i);
      #1;
    end
    ready_i = 1'b1;
    send_beat(8'h55, 1'b0);
    chk("t3_valid_after", 64'(valid_o), 64'd0);
    chk("t3_data_after",  64'(data_o),  64'h00000055);
    chk("t3_keep_after",  64'(keep_o),  64'h1);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b0);
    chk("t3_next_data", 64'(data_o), 64'h88776655);
    tick(2);

    // 4: single last beat pushed while a beat is popped
    ready_i = 1'b0;
    send_beat(8'hD1, 1'b0);
    send_beat(8'hD2, 1'b1);
    tick(2);
    ready_i = 1'b1;
    send_beat(8'h77, 1'b1);
    chk("t4_valid", 64'(valid_o), 64'd1);
    chk("t4_data",  64'(data_o),  64'h00000077);
    chk("t4_keep",  64'(keep_o),  64'h1);
    chk("t4_last",  64'(last_o),  64'd1);
    tick(2);

    // 5: synchronous clear discards a partial beat
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    model_clear();
    chk("t5_clr_keep", 64'(keep_o), 64'd0);
    chk("t5_clr_data", 64'(data_o), 64'd0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b0);
    chk("t5_data", 64'(data_o), 64'h04030201);
    tick(2);

`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
    // 6: counter wrap over five wide beats
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    model_clear();
    for (int unsigned i = 0; i < 5; i++) send_beat(8'(8'h30 + i), 1'b1);
    tick(2);
    chk("t6_cnt_wrap", 64'(wbeat_cnt_o), 64'd1);
`endif

    // async reset mid-beat takes effect without a clock edge
    ready_i = 1'b0;
    send_beat(8'hF1, 1'b0);
    send_beat(8'hF2, 1'b0);
    send_beat(8'hF3, 1'b0);
    send_beat(8'hF4, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_keep",  64'(keep_o),  64'd0);
    chk("arst_data",  64'(data_o),  64'd0);
`ifdef STREAM_UPSIZER_WBEAT_CNT_EN
    chk("arst_cnt",   64'(wbeat_cnt_o), 64'd0);
`endif
    q.delete();
    model_clear();
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    ready_i = 1'b1;
    send_beat(8'h0A, 1'b0);
    send_beat(8'h0B, 1'b1);
    chk("arst_after_data", 64'(data_o), 64'h00000B0A);
    tick(4);

    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 64'd1, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
